// File: rtl/traffic_scheduler.sv
// traffic_scheduler: round-robin packet command generator for the command FIFO
// that feeds the AXI-Stream packet builder.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start, stop     run control pulses (start latches cfg_* in IDLE)
//   cfg_*           per-stream traffic profiles, stream i in slice i
//   fifo_full       command FIFO full
//   fifo_wr_enable  command FIFO write strobe (combinational: slot valid and not full)
//   size..payload   command fields held in the one-deep output slot
//   busy            high while running or draining
//   done            one-cycle pulse when a run has fully drained
//   total_sent      commands written this run, saturating
module traffic_scheduler #(
    parameter int unsigned N_STREAMS = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned GAP_WIDTH = 16,
    parameter int unsigned MIN_SIZE  = 64,
    parameter int unsigned MAX_SIZE  = 1518
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic [N_STREAMS-1:0]           cfg_enable,
    input  logic [N_STREAMS*11-1:0]        cfg_size,
    input  logic [N_STREAMS*48-1:0]        cfg_d_mac,
    input  logic [N_STREAMS*48-1:0]        cfg_s_mac,
    input  logic [N_STREAMS*16-1:0]        cfg_ethertype,
    input  logic [N_STREAMS*8-1:0]         cfg_payload,
    input  logic [N_STREAMS*CNT_WIDTH-1:0] cfg_count,
    input  logic [N_STREAMS*GAP_WIDTH-1:0] cfg_gap,
    input  logic                           fifo_full,
    output logic                           fifo_wr_enable,
    output logic [10:0]                    size,
    output logic [47:0]                    d_mac,
    output logic [47:0]                    s_mac,
    output logic [15:0]                    ethertype,
    output logic [7:0]                     payload,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_WIDTH-1:0]           total_sent
);

    localparam int unsigned IDX_W  = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;
    localparam int unsigned SIZE_W = 11;
    localparam logic [SIZE_W-1:0] MIN_S = SIZE_W'(MIN_SIZE);
    localparam logic [SIZE_W-1:0] MAX_S = SIZE_W'(MAX_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t state_q, state_d;
    logic   busy_d, done_d, grant, launch, slot_accept;

    logic                 sh_en    [N_STREAMS];
    logic [SIZE_W-1:0]    sh_size  [N_STREAMS];
    logic [47:0]          sh_d_mac [N_STREAMS];
    logic [47:0]          sh_s_mac [N_STREAMS];
    logic [15:0]          sh_eth   [N_STREAMS];
    logic [7:0]           sh_pay   [N_STREAMS];
    logic [CNT_WIDTH-1:0] sh_count [N_STREAMS];
    logic [GAP_WIDTH-1:0] sh_gap   [N_STREAMS];
    logic [CNT_WIDTH-1:0] rem_q    [N_STREAMS];
    logic [GAP_WIDTH-1:0] gap_q    [N_STREAMS];

    logic [IDX_W-1:0]     rr_q, pick, cand;
    logic                 found, all_done, cmd_valid;
    logic [N_STREAMS-1:0] elig;
    logic [SIZE_W-1:0]    pick_size;
    int                   idx_sum;

    assign fifo_wr_enable = cmd_valid & ~fifo_full;
    assign slot_accept    = ~cmd_valid | fifo_wr_enable;

    // Eligibility per stream; all_done when no enabled stream has work left
    always_comb begin
        all_done = 1'b1;
        elig     = '0;
        for (int i = 0; i < int'(N_STREAMS); i++) begin
            if (sh_en[i] && (sh_count[i] == '0 || rem_q[i] != '0)) begin
                all_done = 1'b0;
                elig[i]  = (gap_q[i] == '0);
            end
        end
    end

    // Round-robin pick: first eligible index scanning from rr_q upward
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        idx_sum = 0;
        for (int k = 0; k < int'(N_STREAMS); k++) begin
            idx_sum = int'(rr_q) + k;
            cand    = IDX_W'(idx_sum % int'(N_STREAMS));
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Size clamp for the granted stream
    always_comb begin
        pick_size = sh_size[pick];
        if (pick_size < MIN_S) begin
            pick_size = MIN_S;
        end else if (pick_size > MAX_S) begin
            pick_size = MAX_S;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    launch  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop || all_done) begin
                    state_d = S_DRAIN;
                end else if (slot_accept && found) begin
                    grant = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!cmd_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State register and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Shadow configuration, remaining counters, gap timers and rr pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= '0;
            for (int i = 0; i < int'(N_STREAMS); i++) begin
                sh_en[i]    <= 1'b0;
                sh_size[i]  <= '0;
                sh_d_mac[i] <= '0;
                sh_s_mac[i] <= '0;
                sh_eth[i]   <= '0;
                sh_pay[i]   <= '0;
                sh_count[i] <= '0;
                sh_gap[i]   <= '0;
                rem_q[i]    <= '0;
                gap_q[i]    <= '0;
            end
        end else if (launch) begin
            rr_q <= '0;
            for (int i = 0; i < int'(N_STREAMS); i++) begin
                sh_en[i]    <= cfg_enable[i];
                sh_size[i]  <= cfg_size[i*11 +: 11];
                sh_d_mac[i] <= cfg_d_mac[i*48 +: 48];
                sh_s_mac[i] <= cfg_s_mac[i*48 +: 48];
                sh_eth[i]   <= cfg_ethertype[i*16 +: 16];
                sh_pay[i]   <= cfg_payload[i*8 +: 8];
                sh_count[i] <= cfg_count[i*CNT_WIDTH +: CNT_WIDTH];
                sh_gap[i]   <= cfg_gap[i*GAP_WIDTH +: GAP_WIDTH];
                rem_q[i]    <= cfg_count[i*CNT_WIDTH +: CNT_WIDTH];
                gap_q[i]    <= '0;
            end
        end else begin
            if (grant) begin
                rr_q <= (pick == IDX_W'(N_STREAMS - 1)) ? '0 : pick + IDX_W'(1);
            end
            for (int i = 0; i < int'(N_STREAMS); i++) begin
                if (grant && pick == IDX_W'(i)) begin
                    if (sh_count[i] != '0) begin
                        rem_q[i] <= rem_q[i] - CNT_WIDTH'(1);
                    end
                    gap_q[i] <= sh_gap[i];
                end else if (gap_q[i] != '0) begin
                    gap_q[i] <= gap_q[i] - GAP_WIDTH'(1);
                end
            end
        end
    end

    // One-deep output slot and the saturating write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid  <= 1'b0;
            size       <= '0;
            d_mac      <= '0;
            s_mac      <= '0;
            ethertype  <= '0;
            payload    <= '0;
            total_sent <= '0;
        end else begin
            if (grant) begin
                cmd_valid <= 1'b1;
                size      <= pick_size;
                d_mac     <= sh_d_mac[pick];
                s_mac     <= sh_s_mac[pick];
                ethertype <= sh_eth[pick];
                payload   <= sh_pay[pick];
            end else if (fifo_wr_enable) begin
                cmd_valid <= 1'b0;
            end
            if (launch) begin
                total_sent <= '0;
            end else if (fifo_wr_enable && total_sent != '1) begin
                total_sent <= total_sent + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb_traffic_scheduler: directed and randomized runs of traffic_scheduler checked
// against a transaction-level model that tracks per-stream "eligible-from" times.
module tb_traffic_scheduler;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int GW = 16;

    logic            clk, rst, start, stop, fifo_full;
    logic [N-1:0]    cfg_enable;
    logic [N*11-1:0] cfg_size;
    logic [N*48-1:0] cfg_d_mac, cfg_s_mac;
    logic [N*16-1:0] cfg_ethertype;
    logic [N*8-1:0]  cfg_payload;
    logic [N*CW-1:0] cfg_count;
    logic [N*GW-1:0] cfg_gap;
    logic            fifo_wr_enable, busy, done;
    logic [10:0]     size;
    logic [47:0]     d_mac, s_mac;
    logic [15:0]     ethertype;
    logic [7:0]      payload;
    logic [CW-1:0]   total_sent;

    traffic_scheduler #(.N_STREAMS(N), .CNT_WIDTH(CW), .GAP_WIDTH(GW),
                        .MIN_SIZE(64), .MAX_SIZE(1518)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_enable(cfg_enable), .cfg_size(cfg_size), .cfg_d_mac(cfg_d_mac),
        .cfg_s_mac(cfg_s_mac), .cfg_ethertype(cfg_ethertype), .cfg_payload(cfg_payload),
        .cfg_count(cfg_count), .cfg_gap(cfg_gap), .fifo_full(fifo_full),
        .fifo_wr_enable(fifo_wr_enable), .size(size), .d_mac(d_mac), .s_mac(s_mac),
        .ethertype(ethertype), .payload(payload), .busy(busy), .done(done),
        .total_sent(total_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side configuration, packed onto the DUT buses
    logic        c_en   [N];
    logic [10:0] c_size [N];
    logic [47:0] c_dmac [N];
    logic [47:0] c_smac [N];
    logic [15:0] c_eth  [N];
    logic [7:0]  c_pay  [N];
    logic [31:0] c_cnt  [N];
    logic [15:0] c_gap  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cfg_enable[i]             = c_en[i];
            cfg_size[i*11 +: 11]      = c_size[i];
            cfg_d_mac[i*48 +: 48]     = c_dmac[i];
            cfg_s_mac[i*48 +: 48]     = c_smac[i];
            cfg_ethertype[i*16 +: 16] = c_eth[i];
            cfg_payload[i*8 +: 8]     = c_pay[i];
            cfg_count[i*CW +: CW]     = c_cnt[i];
            cfg_gap[i*GW +: GW]       = c_gap[i];
        end
    end

    // Model state
    logic        s_en   [N];
    logic [10:0] s_size [N];
    logic [47:0] s_dmac [N];
    logic [47:0] s_smac [N];
    logic [15:0] s_eth  [N];
    logic [7:0]  s_pay  [N];
    logic [31:0] s_cnt  [N];
    longint      s_gap  [N];
    longint      left   [N];
    longint      ready_at [N];
    longint      cyc;
    int          m_phase;   // 0 idle, 1 running, 2 draining
    int          m_rr;
    bit          m_valid, m_done, m_busy;
    logic [10:0] m_size;
    logic [47:0] m_dmac, m_smac;
    logic [15:0] m_eth;
    logic [7:0]  m_pay;
    logic [31:0] m_sent;

    int     n_checks = 0;
    int     n_errors = 0;
    int     done_seen;
    int     obs_src [$];
    longint obs_cyc [$];
    int     obs_size [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] clampsz(input logic [10:0] s);
        if (s < 11'd64)   return 11'd64;
        if (s > 11'd1518) return 11'd1518;
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_valid = 0; m_done = 0; m_busy = 0; m_sent = '0;
        m_size = '0; m_dmac = '0; m_smac = '0; m_eth = '0; m_pay = '0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0; ready_at[i] = 0;
        end
    endtask

    task automatic sent_inc();
        if (m_sent != 32'hFFFF_FFFF) m_sent = m_sent + 32'd1;
    endtask

    // Advance the model across one clock edge given the inputs seen before it
    task automatic model_advance(input bit st, input bit sp, input bit fl);
        bit wr, all_done, found;
        int g, i;
        wr = m_valid && !fl;
        m_done = 0;
        g = 0;
        case (m_phase)
            0: if (st && !sp) begin
                for (int k = 0; k < N; k++) begin
                    s_en[k] = c_en[k]; s_size[k] = c_size[k]; s_dmac[k] = c_dmac[k];
                    s_smac[k] = c_smac[k]; s_eth[k] = c_eth[k]; s_pay[k] = c_pay[k];
                    s_cnt[k] = c_cnt[k]; s_gap[k] = longint'(c_gap[k]);
                    left[k] = longint'(c_cnt[k]); ready_at[k] = 0;
                end
                m_rr = 0; m_sent = '0; m_phase = 1;
            end
            1: begin
                if (wr) begin sent_inc(); m_valid = 0; end
                all_done = 1;
                for (int k = 0; k < N; k++)
                    if (s_en[k] && (s_cnt[k] == 0 || left[k] > 0)) all_done = 0;
                if (sp || all_done) begin
                    m_phase = 2;
                end else if (!m_valid) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        i = (m_rr + k) % N;
                        if (!found && s_en[i] && (s_cnt[i] == 0 || left[i] > 0) && cyc >= ready_at[i]) begin
                            found = 1; g = i;
                        end
                    end
                    if (found) begin
                        m_valid = 1; m_size = clampsz(s_size[g]); m_dmac = s_dmac[g];
                        m_smac = s_smac[g]; m_eth = s_eth[g]; m_pay = s_pay[g];
                        m_rr = (g + 1) % N;
                        if (s_cnt[g] != 0) left[g] = left[g] - 1;
                        ready_at[g] = cyc + s_gap[g] + 1;
                    end
                end
            end
            default: begin
                if (!m_valid) begin m_phase = 0; m_done = 1; end
                if (wr) begin sent_inc(); m_valid = 0; end
            end
        endcase
        m_busy = (m_phase != 0);
        cyc++;
    endtask

    // One cycle: drive inputs, compare outputs against the model, advance
    task automatic step(input bit st, input bit sp, input bit fl);
        start = st; stop = sp; fifo_full = fl;
        #1;
        chk("wr_en", 64'(fifo_wr_enable), 64'(m_valid && !fl));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("total_sent", 64'(total_sent), 64'(m_sent));
        if (m_valid) begin
            chk("size", 64'(size), 64'(m_size));
            chk("d_mac", 64'(d_mac), 64'(m_dmac));
            chk("s_mac", 64'(s_mac), 64'(m_smac));
            chk("ethertype", 64'(ethertype), 64'(m_eth));
            chk("payload", 64'(payload), 64'(m_pay));
        end
        if (done) done_seen++;
        if (fifo_wr_enable) begin
            obs_src.push_back(int'(d_mac[7:0]));
            obs_cyc.push_back(cyc);
            obs_size.push_back(int'(size));
        end
        model_advance(st, sp, fl);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_default();
        for (int i = 0; i < N; i++) begin
            c_en[i] = 0; c_size[i] = 11'd100;
            c_dmac[i] = {40'h02_11_22_33_44, 8'(i)};
            c_smac[i] = {40'h0A_55_66_77_88, 8'(i)};
            c_eth[i] = 16'h0800 + 16'(i); c_pay[i] = 8'hA0 + 8'(i);
            c_cnt[i] = 32'd1; c_gap[i] = 16'd0;
        end
    endtask

    task automatic cfg_scramble();
        for (int i = 0; i < N; i++) begin
            c_en[i] = 1'($urandom); c_size[i] = 11'($urandom);
            c_dmac[i] = {16'($urandom), 32'($urandom)}; c_smac[i] = {16'($urandom), 32'($urandom)};
            c_eth[i] = 16'($urandom); c_pay[i] = 8'($urandom);
            c_cnt[i] = 32'($urandom_range(3)); c_gap[i] = 16'($urandom_range(7));
        end
    endtask

    task automatic clear_obs();
        obs_src.delete(); obs_cyc.delete(); obs_size.delete(); done_seen = 0;
    endtask

    // Start a run and step until done is seen or the cycle budget runs out
    task automatic run(input int max_cyc, input int stop_at, input int full_pct,
                       input int full_lo, input int full_hi, input bit rnd);
        bit fin, fl, st;
        fin = 0;
        for (int i = 0; i < max_cyc && !fin; i++) begin
            fl = (full_pct > 0 && int'($urandom_range(99)) < full_pct) || (i >= full_lo && i <= full_hi);
            st = (i == 0) || (rnd && m_phase == 1 && $urandom_range(15) == 0);
            step(st, i == stop_at, fl);
            if (i == 0 && rnd) cfg_scramble();
            if (done_seen > 0) fin = 1;
        end
        chk("run_terminates", 64'(fin), 64'd1);
        step(0, 0, 0);
    endtask

    int     exp_order [6] = '{0, 1, 2, 0, 1, 2};
    longint base, last0, mingap;
    bit     b2b;
    int     nwin, n1;

    initial begin
        rst = 1; start = 0; stop = 0; fifo_full = 0; cyc = 0;
        cfg_default();
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr", 64'(fifo_wr_enable), 64'd0);
        chk("rst_total", 64'(total_sent), 64'd0);
        chk("rst_fields", {5'd0, size, d_mac}, 64'd0);
        rst = 0;

        // Single stream, three packets back to back
        cfg_default(); c_en[0] = 1; c_cnt[0] = 32'd3; clear_obs();
        run(60, -1, 0, -1, -1, 0);
        chk("s1_writes", 64'(obs_src.size()), 64'd3);
        chk("s1_total", 64'(total_sent), 64'd3);
        chk("s1_done_pulses", 64'(done_seen), 64'd1);
        chk("s1_busy_end", 64'(busy), 64'd0);
        if (obs_cyc.size() == 3) chk("s1_consecutive", 64'(obs_cyc[2] - obs_cyc[0]), 64'd2);
        foreach (obs_size[k]) chk("s1_size", 64'(obs_size[k]), 64'd100);

        // Round robin across three streams
        cfg_default(); clear_obs();
        for (int i = 0; i < 3; i++) begin c_en[i] = 1; c_cnt[i] = 32'd2; end
        run(60, -1, 0, -1, -1, 0);
        chk("s2_writes", 64'(obs_src.size()), 64'd6);
        chk("s2_total", 64'(total_sent), 64'd6);
        for (int k = 0; k < 6 && k < obs_src.size(); k++) chk("s2_order", 64'(obs_src[k]), 64'(exp_order[k]));

        // Gap on stream 0, stream 1 fills in; stop while unlimited
        cfg_default(); clear_obs();
        c_en[0] = 1; c_cnt[0] = 0; c_gap[0] = 16'd5;
        c_en[1] = 1; c_cnt[1] = 0;
        run(100, 20, 0, -1, -1, 0);
        last0 = -1; mingap = 1000; b2b = 1; n1 = 0;
        foreach (obs_src[k]) begin
            if (obs_src[k] == 0) begin
                if (last0 >= 0 && obs_cyc[k] - last0 < mingap) mingap = obs_cyc[k] - last0;
                last0 = obs_cyc[k];
            end else n1++;
            if (k > 0 && obs_cyc[k] != obs_cyc[k-1] + 1) b2b = 0;
        end
        chk("s3_gap_min6", 64'(mingap >= 6), 64'd1);
        chk("s3_fill_b2b", 64'(b2b), 64'd1);
        chk("s3_s1_active", 64'(n1 > 6), 64'd1);
        chk("s3_done_pulses", 64'(done_seen), 64'd1);

        // Size clamping at both ends
        cfg_default(); clear_obs();
        c_en[0] = 1; c_size[0] = 11'd20; c_en[1] = 1; c_size[1] = 11'd2000;
        run(60, -1, 0, -1, -1, 0);
        chk("s4_writes", 64'(obs_src.size()), 64'd2);
        foreach (obs_src[k])
            chk(obs_src[k] == 0 ? "s4_size_low" : "s4_size_high", 64'(obs_size[k]),
                obs_src[k] == 0 ? 64'd64 : 64'd1518);

        // FIFO full held for ten cycles with a pending command
        cfg_default(); clear_obs(); c_en[2] = 1; c_cnt[2] = 32'd2;
        base = cyc;
        run(80, -1, 0, 2, 11, 0);
        nwin = 0;
        foreach (obs_cyc[k]) if (obs_cyc[k] >= base + 2 && obs_cyc[k] <= base + 11) nwin++;
        chk("s5_no_write_full", 64'(nwin), 64'd0);
        chk("s5_writes", 64'(obs_src.size()), 64'd2);
        chk("s5_total", 64'(total_sent), 64'd2);

        // start together with stop is ignored
        step(1, 1, 0);
        chk("startstop_busy", 64'(busy), 64'd0);

        // Reset in the middle of a run with a command pending
        cfg_default(); clear_obs(); c_en[0] = 1; c_cnt[0] = 0;
        step(1, 0, 0);
        repeat (4) step(0, 0, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_wr", 64'(fifo_wr_enable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_total", 64'(total_sent), 64'd0);
        chk("mid_rst_fields", {5'd0, size, d_mac}, 64'd0);
        @(negedge clk);
        chk("mid_rst_no_done", 64'(done), 64'd0);
        rst = 0;
        model_reset(); clear_obs();
        cfg_default(); c_en[0] = 1; c_cnt[0] = 32'd3;
        run(60, -1, 0, -1, -1, 0);
        chk("after_rst_total", 64'(total_sent), 64'd3);
        chk("after_rst_done", 64'(done_seen), 64'd1);

        // Randomized runs with backpressure, mid-run cfg changes and stray starts
        for (int r = 0; r < 10; r++) begin
            clear_obs();
            cfg_default();
            for (int i = 0; i < N; i++) begin
                c_en[i] = 1'($urandom); c_size[i] = 11'($urandom);
                c_dmac[i] = {16'($urandom), 24'($urandom), 8'(i)};
                c_smac[i] = {16'($urandom), 32'($urandom)};
                c_eth[i] = 16'($urandom); c_pay[i] = 8'($urandom);
                c_cnt[i] = 32'($urandom_range(5)); c_gap[i] = 16'($urandom_range(4));
            end
            run(400, int'($urandom_range(60, 10)), 25, -1, -1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
